lcd_update_arbiter: RTL and testbench

- Shares the 11-character LCD line between two requesters: the calculator result path and a status-message path.
- Each requester presents a complete 88-bit character frame, with char 10 in bits [87:80] (leftmost) and char 0 in bits [7:0].
- Arbitrates between requests, shows a message frame temporarily, applies per-character blinking, and hands finished frames to the LCD driver over a valid/ready handshake.

---
 rtl/lcd_update_arbiter.sv | 279 +++++++++++++++++++++++++++
 tb/tb_lcd_update_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_update_arbiter.sv
// ---------------------------------------------------------------------------
// lcd_update_arbiter
//
// Shares the single 11-character LCD line between the calculator result path
// and a status-message path. Requests are arbitrated (round-robin when both
// are present), a message frame is shown for HOLD_CYCLES before the stored
// calculator frame is brought back, selected characters blink with a
// BLINK_DIV half-period, and each finished frame is handed to the LCD driver
// over a valid/ready handshake.
//
// Ports:
//   CLK_50M      in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   req_calc     in   calculator update request (level, held until gnt_calc)
//   calc_frame   in   88-bit calculator frame, char 10 in [87:80], char 0 in [7:0]
//   req_msg      in   status-message update request (level, held until gnt_msg)
//   msg_frame    in   88-bit message frame, same layout
//   blink_mask   in   bit i = 1 makes char i blink
//   gnt_calc     out  one-cycle pulse, calc_frame captured
//   gnt_msg      out  one-cycle pulse, msg_frame captured
//   frame_out    out  frame presented to the LCD driver
//   upd_valid    out  frame_out valid, waiting for upd_ready
//   upd_ready    in   driver accepts frame_out
//   lcd_busy     in   driver still writing the panel
//   showing_msg  out  message frame is the current display source
// ---------------------------------------------------------------------------
module lcd_update_arbiter #(
  parameter int unsigned BLINK_DIV   = 25000000,
  parameter int unsigned HOLD_CYCLES = 100000000
) (
  input  logic        CLK_50M,
  input  logic        rst_n,
  input  logic        req_calc,
  input  logic [87:0] calc_frame,
  input  logic        req_msg,
  input  logic [87:0] msg_frame,
  input  logic [10:0] blink_mask,
  output logic        gnt_calc,
  output logic        gnt_msg,
  output logic [87:0] frame_out,
  output logic        upd_valid,
  input  logic        upd_ready,
  input  logic        lcd_busy,
  output logic        showing_msg
);

  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [BW-1:0] BLINK_ONE  = BW'(1);
  localparam logic [BW-1:0] BLINK_ZERO = BW'(0);
  localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_ONE   = HW'(1);
  localparam logic [HW-1:0] HOLD_ZERO  = HW'(0);
  localparam logic [87:0]   SPACES     = {11{8'h20}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            enter_send_s;
  logic            grant_calc_s, grant_msg_s;
  logic            hold_expire_s, blink_wrap_s;

  logic [87:0]     calc_shadow_q, calc_shadow_d;
  logic [87:0]     msg_shadow_q, msg_shadow_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic            showing_msg_q, showing_msg_d;
  logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
  logic            blink_phase_q, blink_phase_d;
  logic            refresh_pending_q, refresh_pending_d;
  logic            last_msg_q, last_msg_d;      // 1: msg was granted last
  logic            upd_valid_q, upd_valid_d;
  logic            gnt_calc_q, gnt_calc_d;
  logic            gnt_msg_q, gnt_msg_d;
  logic [87:0]     frame_out_q, frame_out_d;
  logic [87:0]     src_frame_s;
  logic [87:0]     comp_frame_s;

  // Arbitration: grants are only issued while idle; ties go to the side not granted last.
  always_comb begin
    grant_calc_s = 1'b0;
    grant_msg_s  = 1'b0;
    if (state_q == ST_IDLE) begin
      if (req_calc && req_msg) begin
        if (last_msg_q) begin
          grant_calc_s = 1'b1;
        end else begin
          grant_msg_s = 1'b1;
        end
      end else if (req_calc) begin
        grant_calc_s = 1'b1;
      end else if (req_msg) begin
        grant_msg_s = 1'b1;
      end else begin
        grant_calc_s = 1'b0;
        grant_msg_s  = 1'b0;
      end
    end else begin
      grant_calc_s = 1'b0;
      grant_msg_s  = 1'b0;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d      = state_q;
    enter_send_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_calc || req_msg || refresh_pending_q) begin
          state_d      = ST_SEND;
          enter_send_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (upd_valid_q && upd_ready) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_WAIT: begin
        if (!lcd_busy) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Shadows, round-robin pointer, hold and blink counters, refresh flag.
  always_comb begin
    if (grant_calc_s) begin
      calc_shadow_d = calc_frame;
    end else begin
      calc_shadow_d = calc_shadow_q;
    end

    if (grant_msg_s) begin
      msg_shadow_d = msg_frame;
    end else begin
      msg_shadow_d = msg_shadow_q;
    end

    if (grant_msg_s) begin
      last_msg_d = 1'b1;
    end else if (grant_calc_s) begin
      last_msg_d = 1'b0;
    end else begin
      last_msg_d = last_msg_q;
    end

    // A message grant on the expiry edge wins: it reloads instead of expiring.
    hold_expire_s = 1'b0;
    if (grant_msg_s) begin
      hold_cnt_d    = HOLD_LOAD;
      showing_msg_d = 1'b1;
    end else if (showing_msg_q) begin
      if (hold_cnt_q <= HOLD_ONE) begin
        hold_cnt_d    = HOLD_ZERO;
        showing_msg_d = 1'b0;
        hold_expire_s = 1'b1;
      end else begin
        hold_cnt_d    = hold_cnt_q - HOLD_ONE;
        showing_msg_d = 1'b1;
      end
    end else begin
      hold_cnt_d    = hold_cnt_q;
      showing_msg_d = 1'b0;
    end

    blink_wrap_s = 1'b0;
    if (blink_mask == 11'h000) begin
      blink_cnt_d   = BLINK_ZERO;
      blink_phase_d = 1'b1;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d   = BLINK_ZERO;
      blink_phase_d = ~blink_phase_q;
      blink_wrap_s  = 1'b1;
    end else begin
      blink_cnt_d   = blink_cnt_q + BLINK_ONE;
      blink_phase_d = blink_phase_q;
    end

    // Events coinciding with entry to SEND are already reflected in the
    // frame composed from the next-state values, so they are not kept.
    if (enter_send_s) begin
      refresh_pending_d = 1'b0;
    end else begin
      refresh_pending_d = refresh_pending_q | hold_expire_s | blink_wrap_s;
    end
  end

  // Output logic: frame composition on SEND entry, handshake and grant pulses.
  always_comb begin
    if (showing_msg_d) begin
      src_frame_s = msg_shadow_d;
    end else begin
      src_frame_s = calc_shadow_d;
    end

    comp_frame_s = src_frame_s;
    for (int i = 0; i < 11; i++) begin
      if (blink_mask[i] && !blink_phase_d) begin
        comp_frame_s[i*8 +: 8] = 8'h20;
      end else begin
        comp_frame_s[i*8 +: 8] = src_frame_s[i*8 +: 8];
      end
    end

    if (enter_send_s) begin
      frame_out_d = comp_frame_s;
    end else begin
      frame_out_d = frame_out_q;
    end

    upd_valid_d = (state_d == ST_SEND);
    gnt_calc_d  = grant_calc_s;
    gnt_msg_d   = grant_msg_s;
  end

  // FSM state register.
  always_ff @(posedge CLK_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge CLK_50M or negedge rst_n) begin
    if (!rst_n) begin
      calc_shadow_q     <= SPACES;
      msg_shadow_q      <= SPACES;
      hold_cnt_q        <= HOLD_ZERO;
      showing_msg_q     <= 1'b0;
      blink_cnt_q       <= BLINK_ZERO;
      blink_phase_q     <= 1'b1;
      refresh_pending_q <= 1'b0;
      last_msg_q        <= 1'b0;
      upd_valid_q       <= 1'b0;
      gnt_calc_q        <= 1'b0;
      gnt_msg_q         <= 1'b0;
      frame_out_q       <= SPACES;
    end else begin
      calc_shadow_q     <= calc_shadow_d;
      msg_shadow_q      <= msg_shadow_d;
      hold_cnt_q        <= hold_cnt_d;
      showing_msg_q     <= showing_msg_d;
      blink_cnt_q       <= blink_cnt_d;
      blink_phase_q     <= blink_phase_d;
      refresh_pending_q <= refresh_pending_d;
      last_msg_q        <= last_msg_d;
      upd_valid_q       <= upd_valid_d;
      gnt_calc_q        <= gnt_calc_d;
      gnt_msg_q         <= gnt_msg_d;
      frame_out_q       <= frame_out_d;
    end
  end

  assign gnt_calc    = gnt_calc_q;
  assign gnt_msg     = gnt_msg_q;
  assign frame_out   = frame_out_q;
  assign upd_valid   = upd_valid_q;
  assign showing_msg = showing_msg_q;

endmodule

// File: tb/tb_lcd_update_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for lcd_update_arbiter (BLINK_DIV=8, HOLD_CYCLES=20).
// A table of single-cycle vectors covers the basic grant / handshake flow and
// the simultaneous-request tie; hand-written sequences cover hold expiry,
// blinking, a stalled handshake, lcd_busy and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_lcd_update_arbiter;

  localparam logic [87:0] SP      = {11{8'h20}};
  localparam logic [87:0] F_HELLO = "HELLO      ";
  localparam logic [87:0] F_CALC  = "CALC  12345";
  localparam logic [87:0] F_ERR   = "ERROR 00001";
  localparam logic [87:0] F_MSG2  = "HI THERE   ";
  localparam logic [87:0] F_PI    = "3.14159    ";

  logic        clk;
  logic        rst_n;
  logic        req_calc;
  logic [87:0] calc_frame;
  logic        req_msg;
  logic [87:0] msg_frame;
  logic [10:0] blink_mask;
  logic        gnt_calc;
  logic        gnt_msg;
  logic [87:0] frame_out;
  logic        upd_valid;
  logic        upd_ready;
  logic        lcd_busy;
  logic        showing_msg;

  int n_vec;
  int n_err;

  lcd_update_arbiter #(
    .BLINK_DIV   (8),
    .HOLD_CYCLES (20)
  ) dut (
    .CLK_50M     (clk),
    .rst_n       (rst_n),
    .req_calc    (req_calc),
    .calc_frame  (calc_frame),
    .req_msg     (req_msg),
    .msg_frame   (msg_frame),
    .blink_mask  (blink_mask),
    .gnt_calc    (gnt_calc),
    .gnt_msg     (gnt_msg),
    .frame_out   (frame_out),
    .upd_valid   (upd_valid),
    .upd_ready   (upd_ready),
    .lcd_busy    (lcd_busy),
    .showing_msg (showing_msg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rc;
    logic [87:0] cf;
    logic        rm;
    logic [87:0] mf;
    logic        rdy;
    logic        busy;
    logic        e_gc;
    logic        e_gm;
    logic        e_v;
    logic        e_sm;
    logic [87:0] e_fo;
  } vec_t;

  vec_t tbl[10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [87:0] act, input logic [87:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic gc, input logic gm, input logic v,
                         input logic sm, input logic [87:0] fo);
    chk({nm, " gnt_calc"},    {87'd0, gnt_calc},    {87'd0, gc});
    chk({nm, " gnt_msg"},     {87'd0, gnt_msg},     {87'd0, gm});
    chk({nm, " upd_valid"},   {87'd0, upd_valid},   {87'd0, v});
    chk({nm, " showing_msg"}, {87'd0, showing_msg}, {87'd0, sm});
    chk({nm, " frame_out"},   frame_out,            fo);
  endtask

  initial begin
    logic [7:0] exp_b;
    n_vec = 0;
    n_err = 0;

    //           rc    cf       rm    mf     rdy   busy  gc    gm    v     sm    fo
    tbl[0] = '{1'b1, F_HELLO, 1'b0, SP,    1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, F_HELLO};
    tbl[1] = '{1'b0, F_HELLO, 1'b0, SP,    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, F_HELLO};
    tbl[2] = '{1'b0, F_HELLO, 1'b0, SP,    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, F_HELLO};
    tbl[3] = '{1'b0, F_HELLO, 1'b0, SP,    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, F_HELLO};
    // simultaneous requests: first tie after reset goes to msg
    tbl[4] = '{1'b1, F_CALC,  1'b1, F_ERR, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, F_ERR};
    tbl[5] = '{1'b1, F_CALC,  1'b0, F_ERR, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, F_ERR};
    tbl[6] = '{1'b1, F_CALC,  1'b0, F_ERR, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, F_ERR};
    // calc granted during the hold: display source stays msg
    tbl[7] = '{1'b1, F_CALC,  1'b0, F_ERR, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, F_ERR};
    tbl[8] = '{1'b0, F_CALC,  1'b0, F_ERR, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, F_ERR};
    tbl[9] = '{1'b0, F_CALC,  1'b0, F_ERR, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, F_ERR};

    rst_n      = 1'b0;
    req_calc   = 1'b0;
    calc_frame = SP;
    req_msg    = 1'b0;
    msg_frame  = SP;
    blink_mask = 11'h000;
    upd_ready  = 1'b1;
    lcd_busy   = 1'b0;

    step();
    step();
    chk_out("reset", 1'b0, 1'b0, 1'b0, 1'b0, SP);
    rst_n = 1'b1;
    step();
    chk_out("post_reset_idle", 1'b0, 1'b0, 1'b0, 1'b0, SP);

    // table-driven single-cycle vectors
    for (int i = 0; i < 10; i++) begin
      req_calc   = tbl[i].rc;
      calc_frame = tbl[i].cf;
      req_msg    = tbl[i].rm;
      msg_frame  = tbl[i].mf;
      upd_ready  = tbl[i].rdy;
      lcd_busy   = tbl[i].busy;
      step();
      chk_out($sformatf("v%0d", i), tbl[i].e_gc, tbl[i].e_gm, tbl[i].e_v, tbl[i].e_sm, tbl[i].e_fo);
    end

    // hold expiry: msg granted 5 edges ago, 14 more edges keep it on screen
    for (int i = 0; i < 14; i++) begin
      step();
      chk($sformatf("hold%0d showing_msg", i), {87'd0, showing_msg}, {87'd0, 1'b1});
    end
    step();
    chk_out("hold_expire", 1'b0, 1'b0, 1'b0, 1'b0, F_ERR);
    step();
    chk_out("calc_restore", 1'b0, 1'b0, 1'b1, 1'b0, F_CALC);
    step();
    step();
    step();
    chk_out("calc_restore_idle", 1'b0, 1'b0, 1'b0, 1'b0, F_CALC);

    // blink char 0 of the calc frame (0x35) with an 8-cycle half-period
    blink_mask = 11'h001;
    for (int k = 0; k < 32; k++) begin
      step();
      if ((k >= 8 && k < 16) || k >= 24) begin
        exp_b = 8'h20;
      end else begin
        exp_b = 8'h35;
      end
      chk($sformatf("blink%0d frame_out", k), frame_out, {F_CALC[87:8], exp_b});
      if (k == 8 || k == 16) begin
        chk($sformatf("blink%0d upd_valid", k), {87'd0, upd_valid}, {87'd0, 1'b1});
      end
    end
    blink_mask = 11'h000;
    for (int i = 0; i < 4; i++) begin
      step();
    end
    chk_out("blink_off", 1'b0, 1'b0, 1'b0, 1'b0, F_CALC);

    // stalled handshake with requests toggling
    upd_ready = 1'b0;
    req_msg   = 1'b1;
    msg_frame = F_MSG2;
    step();
    chk_out("stall_grant", 1'b0, 1'b1, 1'b1, 1'b1, F_MSG2);
    req_msg = 1'b0;
    for (int i = 0; i < 10; i++) begin
      req_calc   = (i % 2 == 0);
      calc_frame = F_HELLO;
      step();
      chk_out($sformatf("stall%0d", i), 1'b0, 1'b0, 1'b1, 1'b1, F_MSG2);
    end
    upd_ready  = 1'b1;
    lcd_busy   = 1'b1;
    req_calc   = 1'b1;
    calc_frame = F_PI;
    step();
    chk_out("stall_accept", 1'b0, 1'b0, 1'b0, 1'b1, F_MSG2);
    for (int i = 0; i < 5; i++) begin
      step();
      chk_out($sformatf("busy%0d", i), 1'b0, 1'b0, 1'b0, 1'b1, F_MSG2);
    end
    lcd_busy = 1'b0;
    step();
    chk_out("busy_release", 1'b0, 1'b0, 1'b0, 1'b1, F_MSG2);
    step();
    chk_out("late_calc_grant", 1'b1, 1'b0, 1'b1, 1'b1, F_MSG2);
    req_calc = 1'b0;
    step();
    chk_out("late_calc_wait", 1'b0, 1'b0, 1'b0, 1'b1, F_MSG2);
    step();
    chk_out("hold2_expire", 1'b0, 1'b0, 1'b0, 1'b0, F_MSG2);
    step();
    chk_out("hold2_restore", 1'b0, 1'b0, 1'b1, 1'b0, F_PI);
    step();
    step();

    // asynchronous reset in the middle of a stalled SEND
    req_calc   = 1'b1;
    calc_frame = F_HELLO;
    upd_ready  = 1'b0;
    step();
    chk_out("pre_reset_send", 1'b1, 1'b0, 1'b1, 1'b0, F_HELLO);
    req_calc = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("async_reset", 1'b0, 1'b0, 1'b0, 1'b0, SP);
    step();
    rst_n     = 1'b1;
    upd_ready = 1'b1;
    step();
    chk_out("after_reset_idle", 1'b0, 1'b0, 1'b0, 1'b0, SP);
    req_calc   = 1'b1;
    calc_frame = F_CALC;
    req_msg    = 1'b1;
    msg_frame  = F_ERR;
    step();
    chk_out("after_reset_tie", 1'b0, 1'b1, 1'b1, 1'b1, F_ERR);
    req_calc = 1'b0;
    req_msg  = 1'b0;
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
